// File: rtl/x_deser_1_to_8_if.sv
// Serial link bundle for the 1:8 deserialiser: serial inputs plus the rebuilt
// parallel lanes, pulses and lane index.
interface x_deser_1_to_8_if;
    logic i_d;
    logic i_vld;
    logic i_sync;
    logic o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h;
    logic o_vld;
    logic o_err;
    logic o_idx_2, o_idx_1, o_idx_0;

    modport master (
        output i_d, i_vld, i_sync,
        input  o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h, o_vld, o_err,
        input  o_idx_2, o_idx_1, o_idx_0
    );

    modport slave (
        input  i_d, i_vld, i_sync,
        output o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h, o_vld, o_err,
        output o_idx_2, o_idx_1, o_idx_0
    );
endinterface

// File: rtl/x_deser_1_to_8.sv
// 1:8 serial-to-parallel receiver for a link serialised by a counter-driven 8:1 mux.
// Lanes 0..6 are staged; lane 7 completes the frame straight into the output registers.
module x_deser_1_to_8 (
    input  logic             i_clk,
    input  logic             i_rst,
    x_deser_1_to_8_if.slave  bus
);
    localparam logic [2:0] LAST_IDX = 3'd7;

    logic [2:0] idx_q,   idx_d;
    logic [6:0] stg_q,   stg_d;
    logic [7:0] lanes_q, lanes_d;
    logic       vld_q,   vld_d;
    logic       err_q,   err_d;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        idx_d   = idx_q;
        stg_d   = stg_q;
        lanes_d = lanes_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;

        if (bus.i_sync) begin
            // Sync drops any partial frame; it is an error only if one was in progress.
            err_d = (idx_q != 3'd0);
            stg_d = 7'd0;
            if (bus.i_vld) begin
                stg_d[0] = bus.i_d;
                idx_d    = 3'd1;
            end else begin
                idx_d    = 3'd0;
            end
        end else if (bus.i_vld) begin
            if (idx_q == LAST_IDX) begin
                lanes_d = {bus.i_d, stg_q};
                vld_d   = 1'b1;
                idx_d   = 3'd0;
            end else begin
                for (int i = 0; i < 7; i++) begin
                    if (idx_q == 3'(i)) stg_d[i] = bus.i_d;
                end
                idx_d = idx_q + 3'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q   <= 3'd0;
            stg_q   <= 7'd0;
            lanes_q <= 8'd0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            stg_q   <= stg_d;
            lanes_q <= lanes_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_a     = lanes_q[0];
    assign bus.o_b     = lanes_q[1];
    assign bus.o_c     = lanes_q[2];
    assign bus.o_d     = lanes_q[3];
    assign bus.o_e     = lanes_q[4];
    assign bus.o_f     = lanes_q[5];
    assign bus.o_g     = lanes_q[6];
    assign bus.o_h     = lanes_q[7];
    assign bus.o_vld   = vld_q;
    assign bus.o_err   = err_q;
    assign bus.o_idx_2 = idx_q[2];
    assign bus.o_idx_1 = idx_q[1];
    assign bus.o_idx_0 = idx_q[0];
endmodule

// File: doc/x_deser_1_to_8.md
Name: x_deser_1_to_8

Overview:
Serial-to-parallel receiver: the far end of a link whose transmitter is an 8:1 mux driven by a 3-bit index counter.
- Accepts one data bit per qualified clock and steers it into lane idx (0..7).
- Presents the completed 8-lane frame on eight individual registered outputs, o_a..o_h, with a one-cycle frame-valid pulse.
- Lane mapping matches the mux: idx 0 -> o_a ... idx 7 -> o_h.
- Used wherever a mux-serialised bus is rebuilt at the receiving board.

Parameters:
None. Fixed 8 lanes, 1 bit per lane, 3-bit index.

Ports:
i_clk      input   1  rising-edge clock
i_rst      input   1  asynchronous, active-high reset
i_d        input   1  serial data bit
i_vld      input   1  i_d is valid this cycle; capture it
i_sync     input   1  frame start; current bit (if i_vld) is lane 0
o_a..o_h   output  1 each  frame lanes 0..7, held between frames
o_vld      output  1  one-cycle pulse: o_a..o_h just updated with a new frame
o_err      output  1  one-cycle pulse: i_sync arrived mid-frame (idx != 0)
o_idx_2, o_idx_1, o_idx_0  output  1 each  lane the next valid bit will write

Behaviour:
- Reset (async, active-high): idx=0, staging[6:0]=0, o_a..o_h=0, o_vld=0, o_err=0. It takes effect immediately, including mid-frame; the partial frame is discarded with no o_vld.
- State: 3-bit idx counter, 7-bit staging register for lanes 0..6, 8 output registers. Lane 7 is never staged; it goes straight to o_h.
- All outputs are registered; no combinational path from inputs to outputs.
- Normal capture (i_vld=1, i_sync=0):
  - idx<7: staging[idx] <= i_d; idx <= idx+1.
  - idx==7: o_a..o_g <= staging[0..6], o_h <= i_d, o_vld <= 1, idx <= 0 (wrap).
- Latency: the edge sampling the lane-7 bit also updates the outputs and raises o_vld, so both are visible the cycle after lane 7 is presented.
- Idle (i_vld=0, i_sync=0): no state change; o_vld=0, o_err=0.
- Gaps: i_vld may deassert for any number of cycles mid-frame; idx and staging hold.
- Sync with data (i_sync=1, i_vld=1):
  - Staging is cleared, then staging[0] <= i_d and idx <= 1.
  - o_err <= 1 if idx was != 0 before the edge.
  - No o_vld, since the partial frame is dropped.
- Sync without data (i_sync=1, i_vld=0): staging cleared, idx <= 0, o_err <= 1 if idx was != 0.
- i_sync while idx==0: legal realignment; no error, no output change.
- o_a..o_h change only on an o_vld edge; they hold the last complete frame indefinitely otherwise.
- o_vld and o_err are never high for two consecutive cycles unless re-triggered by a fresh completion or mid-frame sync. Both can be 0 in the same cycle. They cannot both be 1, because a sync never completes a frame.
- Back-to-back frames at full rate (i_vld held high): o_vld pulses every 8th cycle, no dead cycles.
- {o_idx_2,o_idx_1,o_idx_0} = idx register, MSB first.

Test Plan:
1. Reset then 8 consecutive valid bits i_d = 1,0,1,0,0,1,0,1 (lanes 0..7) -> after 8th edge o_a..o_h = 1,0,1,0,0,1,0,1, o_vld=1 for exactly 1 cycle, idx=0; outputs hold while idle.
2. Same frame with i_vld low for 3 cycles after lanes 2 and 5 -> identical outputs, o_vld only after the lane-7 bit, idx frozen during gaps.
3. Four valid bits (idx=4), then i_sync=1,i_vld=1,i_d=1, then 7 valid bits all 0 -> o_err pulses at the sync edge; frame completes 7 bits later with o_a=1, o_b..o_h=0; no o_vld for the dropped partial frame.
4. 24 bits streamed continuously, frames 0xFF, 0x00, 0x81 (lane-0-first) -> o_vld pulses at cycles 8, 16, 24; outputs change only on those edges; final o_a=1,o_h=1, others 0.
5. Assert i_rst asynchronously (between clock edges) at idx=5 with prior outputs nonzero -> all outputs 0 immediately; next 8 valid bits form a clean frame starting at lane 0.
6. Round trip: counter-driven 8:1 mux serialising random lanes a..h into i_d, i_sync on idx 0 -> 256 frames received bit-exact with o_err never asserted.
